audio_sample_feeder: RTL and testbench

- Upstream stage of the FM modulator.
- Receives signed audio samples from an external controller over a 3-wire serial link (CS, SCLK, MOSI), sampled on the system clock.
- Buffers samples in a small FIFO and releases one per audio sample period, at a fixed rate derived from F_S.
- Output `audio` drives the modulator's signed A-bit audio input directly.

---
 rtl/fm_tx_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/audio_sample_feeder.sv | 179 +++++++++++++++++
 tb/tb_audio_sample_feeder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_tx_pkg.sv
// fm_tx_pkg -- shared constants and helpers for the FM transmitter front end.
// Holds the rate divider derivation and the two's-complement saturation
// limits used by the audio path.
package fm_tx_pkg;

   localparam int A_DEFAULT = 8;

   typedef logic signed [A_DEFAULT-1:0] sample_t;

   // Clocks per output audio sample (integer division).
   function automatic int calc_div(input int f_s, input int f_audio);
      return f_s / f_audio;
   endfunction

   // Largest value representable in an a-bit two's-complement word.
   function automatic int sat_max(input int a);
      return (1 << (a - 1)) - 1;
   endfunction

   // Smallest value representable in an a-bit two's-complement word.
   function automatic int sat_min(input int a);
      return -(1 << (a - 1));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO, depth 2**AW, first-word fall-through.
// dout always shows the head word; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign full      = (r_count == CNT_FULL);
   assign empty     = (r_count == '0);
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   // Storage write.
   // NOTE: the data array has no reset; the count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder -- serial audio receiver, FIFO and fixed-rate sample
// release for the FM modulator. Optional pre-emphasis on the output path is
// enabled by defining AUDIO_PREEMPHASIS_EN.
module audio_sample_feeder
   import fm_tx_pkg::*;
#(
   parameter int A       = 8,
   parameter int F_S     = 50000000,
   parameter int F_AUDIO = 48000,
   parameter int FIFO_AW = 2
`ifdef AUDIO_PREEMPHASIS_EN
   ,
   parameter int PE_SHIFT = 2
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                spi_cs_n,
   input  logic                spi_sclk,
   input  logic                spi_mosi,
   output logic signed [A-1:0] audio,
   output logic                sample_tick,
   output logic                underflow,
   output logic                overflow
);

   localparam int DIV = calc_div(F_S, F_AUDIO);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam int BW  = $clog2(A + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(A - 1);

   logic r_cs_s1, r_cs_s2;
   logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic r_mosi_s1, r_mosi_s2;

   logic [BW-1:0]       r_bitcnt;
   logic [A-1:0]        r_shift;
   logic [A-1:0]        r_word;
   logic                r_push;
   logic [CW-1:0]       r_cnt;
   logic signed [A-1:0] r_audio;
   logic                r_sample_tick;
   logic                r_underflow;
   logic                r_overflow;

   logic                w_rise;
   logic [A-1:0]        w_shift_nxt;
   logic                w_full;
   logic                w_empty;
   logic [A-1:0]        w_fifo_dout;
   logic                w_tick;
   logic                w_pop;
   logic signed [A-1:0] w_x;
   logic signed [A-1:0] w_next_audio;

   assign w_rise      = r_sclk_s2 & ~r_sclk_s3;
   assign w_shift_nxt = {r_shift[A-2:0], r_mosi_s2};
   assign w_tick      = (r_cnt == CNT_LAST);
   assign w_pop       = w_tick & ~w_empty;
   assign w_x         = w_fifo_dout;

   // Two-flop synchronizers, plus a third sclk stage for rising-edge detection.
   // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_s3 <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_cs_s1   <= spi_cs_n;
         r_cs_s2   <= r_cs_s1;
         r_sclk_s1 <= spi_sclk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_s3 <= r_sclk_s2;
         r_mosi_s1 <= spi_mosi;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   // Word assembly: shift on each sclk rise inside a frame, push on the A-th bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_word   <= '0;
         r_push   <= 1'b0;
      end else begin
         r_push <= 1'b0;
         if (r_cs_s2) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
         end else if (w_rise) begin
            r_shift <= w_shift_nxt;
            if (r_bitcnt == BIT_LAST) begin
               r_bitcnt <= '0;
               r_word   <= w_shift_nxt;
               r_push   <= 1'b1;
            end else begin
               r_bitcnt <= r_bitcnt + 1'b1;
            end
         end
      end
   end

   sync_fifo #(
      .W  (A),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_push),
      .din   (r_word),
      .full  (w_full),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .empty (w_empty)
   );

`ifdef AUDIO_PREEMPHASIS_EN
   localparam int PW = A + 2;
   localparam logic signed [PW-1:0] PMAX = PW'(sat_max(A));
   localparam logic signed [PW-1:0] PMIN = PW'(sat_min(A));

   logic signed [A-1:0]  r_x_prev;
   logic signed [PW-1:0] w_x_ext;
   logic signed [PW-1:0] w_prev_ext;
   logic signed [PW-1:0] w_diff;
   logic signed [PW-1:0] w_sum;

   assign w_x_ext    = {{2{w_x[A-1]}}, w_x};
   assign w_prev_ext = {{2{r_x_prev[A-1]}}, r_x_prev};
   assign w_diff     = w_x_ext - w_prev_ext;
   assign w_sum      = w_x_ext + (w_diff >>> PE_SHIFT);

   // Saturate the emphasised sample back into A bits.
   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      w_next_audio = w_sum[A-1:0];
      if (w_sum > PMAX)      w_next_audio = PMAX[A-1:0];
      else if (w_sum < PMIN) w_next_audio = PMIN[A-1:0];
   end

   // Previous raw sample, advanced only when a sample is actually popped.
   always_ff @(posedge clk) begin
      if (rst)        r_x_prev <= '0;
      else if (w_pop) r_x_prev <= w_x;
   end
`else
   assign w_next_audio = w_x;
`endif

   // Rate counter and registered outputs toward the modulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_audio       <= '0;
         r_sample_tick <= 1'b0;
         r_underflow   <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_cnt         <= w_tick ? '0 : r_cnt + 1'b1;
         r_sample_tick <= w_pop;
         r_underflow   <= w_tick & w_empty;
         r_overflow    <= r_push & w_full & ~w_pop;
         if (w_pop) r_audio <= w_next_audio;
      end
   end

   assign audio       = r_audio;
   assign sample_tick = r_sample_tick;
   assign underflow   = r_underflow;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder -- scoreboard bench for audio_sample_feeder.
// Instance a runs at DIV=10 (idle, single word, abort); instance b runs at
// DIV=1000 so bursts outrun the release rate (overflow, full+pop, emphasis).
module tb_audio_sample_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst;
   logic [1:0]        cs_n;
   logic [1:0]        sclk;
   logic [1:0]        mosi;
   logic signed [7:0] audio_a, audio_b;
   logic              tick_a, tick_b, uf_a, uf_b, of_a, of_b;

   audio_sample_feeder #(.A(8), .F_S(1000), .F_AUDIO(100), .FIFO_AW(2)) dut_a (
      .clk(clk), .rst(rst[0]), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
      .audio(audio_a), .sample_tick(tick_a), .underflow(uf_a), .overflow(of_a)
   );

   audio_sample_feeder #(.A(8), .F_S(1000), .F_AUDIO(1), .FIFO_AW(2)) dut_b (
      .clk(clk), .rst(rst[1]), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
      .audio(audio_b), .sample_tick(tick_b), .underflow(uf_b), .overflow(of_b)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int q_a[$];
   int q_b[$];
   int last_exp[2];
   int tick_cnt[2];
   int uf_cnt[2];
   int of_cnt[2];
   int cyc_b;
`ifdef AUDIO_PREEMPHASIS_EN
   int prev[2];
`endif

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int qsize(input int sel);
      return (sel == 1) ? q_b.size() : q_a.size();
   endfunction

   // Expected output for a received word, pushed to that instance's scoreboard.
   task automatic expect_word(input int sel, input logic [7:0] w);
      int x;
      int y;
      x = int'($signed(w));
`ifdef AUDIO_PREEMPHASIS_EN
      y = x + ((x - prev[sel]) >>> 2);
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
      prev[sel] = x;
`else
      y = x;
`endif
      last_exp[sel] = y;
      if (sel == 1) q_b.push_back(y);
      else          q_a.push_back(y);
   endtask

   task automatic clear_counts(input int sel);
      tick_cnt[sel] = 0;
      uf_cnt[sel]   = 0;
      of_cnt[sel]   = 0;
   endtask

   task automatic do_reset(input int sel);
      rst[sel] = 1'b1;
      wait_clk(3);
`ifdef AUDIO_PREEMPHASIS_EN
      prev[sel] = 0;
`endif
      rst[sel] = 1'b0;
   endtask

   // MSB-first bits; sclk low for half clocks, high for half clocks.
   task automatic send_bits(input int sel, input logic [7:0] w, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         mosi[sel] = w[7-i];
         wait_clk(half);
         sclk[sel] = 1'b1;
         wait_clk(half);
         sclk[sel] = 1'b0;
      end
   endtask

   task automatic wait_drain(input int sel, input int budget, input string name);
      int n;
      n = 0;
      while (qsize(sel) != 0 && n < budget) begin
         wait_clk(1);
         n++;
      end
      check(name, qsize(sel), 0);
   endtask

   always @(posedge clk) begin
      if (rst[1]) cyc_b <= 0;
      else        cyc_b <= cyc_b + 1;
   end

   // Monitor for instance a.
   always @(negedge clk) begin
      if (tick_a) begin
         tick_cnt[0]++;
         if (q_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_extra_sample: got audio %0d, expected no sample", audio_a);
         end else begin
            check("a_sample", audio_a, q_a.pop_front());
         end
      end
      if (uf_a) uf_cnt[0]++;
      if (of_a) of_cnt[0]++;
   end

   // Monitor for instance b.
   always @(negedge clk) begin
      if (tick_b) begin
         tick_cnt[1]++;
         if (q_b.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_extra_sample: got audio %0d, expected no sample", audio_b);
         end else begin
            check("b_sample", audio_b, q_b.pop_front());
         end
      end
      if (uf_b) uf_cnt[1]++;
      if (of_b) of_cnt[1]++;
   end

   initial begin
      rst  = 2'b11;
      cs_n = 2'b11;
      sclk = 2'b00;
      mosi = 2'b00;
      clear_counts(0);
      clear_counts(1);
`ifdef AUDIO_PREEMPHASIS_EN
      prev[0] = 0;
      prev[1] = 0;
`endif
      wait_clk(3);

      // Reset state of both instances.
      check("reset_audio_a", audio_a, 0);
      check("reset_tick_a", tick_a, 0);
      check("reset_uf_a", uf_a, 0);
      check("reset_of_a", of_a, 0);
      check("reset_audio_b", audio_b, 0);
      check("reset_tick_b", tick_b, 0);
      check("reset_uf_b", uf_b, 0);
      check("reset_of_b", of_b, 0);

      // Idle: underflow every 10 clocks starting 10 clocks after release.
      rst[0] = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         wait_clk(1);
         check($sformatf("idle_underflow_c%0d", c), uf_a, (c % 10 == 0) ? 1 : 0);
         check("idle_no_tick", tick_a, 0);
      end
      check("idle_audio", audio_a, 0);

      // Single word 0x81.
      clear_counts(0);
      expect_word(0, 8'h81);
      cs_n[0] = 1'b0;
      wait_clk(2);
      send_bits(0, 8'h81, 8, 4);
      wait_clk(2);
      cs_n[0] = 1'b1;
      wait_drain(0, 100, "single_drain");
      clear_counts(0);
      wait_clk(30);
      check("single_hold_audio", audio_a, last_exp[0]);
      check("single_underflow_count", uf_cnt[0], 3);
      check("single_no_extra_tick", tick_cnt[0], 0);

      // Abort after 5 bits of 0xFF, then a complete 0x10.
      do_reset(0);
      clear_counts(0);
      cs_n[0] = 1'b0;
      wait_clk(2);
      send_bits(0, 8'hFF, 5, 4);
      wait_clk(2);
      cs_n[0] = 1'b1;
      wait_clk(6);
      cs_n[0] = 1'b0;
      wait_clk(2);
      expect_word(0, 8'h10);
      send_bits(0, 8'h10, 8, 4);
      wait_clk(2);
      cs_n[0] = 1'b1;
      wait_drain(0, 100, "abort_drain");
      wait_clk(40);
      check("abort_sample_count", tick_cnt[0], 1);
      check("abort_audio", audio_a, last_exp[0]);

      // Burst of six words into a depth-4 FIFO: 5 and 6 are dropped.
      do_reset(1);
      clear_counts(1);
      cs_n[1] = 1'b0;
      wait_clk(2);
      for (int w = 1; w <= 6; w++) begin
         if (w <= 4) expect_word(1, 8'(w));
         send_bits(1, 8'(w), 8, 2);
      end
      wait_clk(2);
      cs_n[1] = 1'b1;
      wait_clk(6);
      check("burst_overflow_count", of_cnt[1], 2);
      check("burst_no_early_tick", tick_cnt[1], 0);

      // Word 7 lands on the first tick cycle while full: push and pop both succeed.
      cs_n[1] = 1'b0;
      wait_clk(2);
      send_bits(1, 8'h07, 7, 2);
      mosi[1] = 1'b1;
      while (cyc_b < 996) wait_clk(1);
      check("full_pop_timing", cyc_b, 996);
      sclk[1] = 1'b1;
      expect_word(1, 8'h07);
      wait_clk(2);
      sclk[1] = 1'b0;
      wait_clk(2);
      cs_n[1] = 1'b1;
      wait_clk(10);
      check("full_pop_no_overflow", of_cnt[1], 2);
      wait_drain(1, 6000, "burst_drain");
      check("burst_tick_count", tick_cnt[1], 5);
      clear_counts(1);
      wait_clk(1010);
      check("burst_hold_underflow", uf_cnt[1], 1);
      check("burst_hold_audio", audio_b, last_exp[1]);

      // Emphasis vectors 0, 100, 127, -128 (plain pass-through when disabled).
      do_reset(1);
      clear_counts(1);
      cs_n[1] = 1'b0;
      wait_clk(2);
      expect_word(1, 8'h00);
      send_bits(1, 8'h00, 8, 2);
      expect_word(1, 8'h64);
      send_bits(1, 8'h64, 8, 2);
      expect_word(1, 8'h7F);
      send_bits(1, 8'h7F, 8, 2);
      expect_word(1, 8'h80);
      send_bits(1, 8'h80, 8, 2);
      wait_clk(2);
      cs_n[1] = 1'b1;
      wait_drain(1, 5000, "pe_drain");
      check("pe_tick_count", tick_cnt[1], 4);
      check("pe_no_overflow", of_cnt[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
